// File: rtl/ldpc_pkg.sv
// ldpc_pkg -- shared definitions for the LDPC extrinsic-message blocks.
//   LDPC_DATA_WIDTH / LDPC_ADDR_WIDTH / LDPC_DEG_WIDTH : default widths
//   seq_state_e : row-pass sequencer states
package ldpc_pkg;

    localparam int LDPC_DATA_WIDTH = 8;
    localparam int LDPC_ADDR_WIDTH = 8;
    localparam int LDPC_DEG_WIDTH  = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/ext_skid_buf.sv
// ext_skid_buf -- 2-entry valid/ready buffer with flow-through when empty.
// A word arriving while the buffer is empty and the consumer is ready passes
// straight to the output; otherwise it is stored. Order is strictly FIFO.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_data     incoming word (no back-pressure; upstream honours count)
//   out_valid, out_data   outgoing stream, transfer on out_valid & out_ready
//   out_ready             consumer ready
//   count                 number of stored words (0..2)
module ext_skid_buf
    import ldpc_pkg::*;
#(
    parameter int DATA_WIDTH = LDPC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic                  empty;
    logic                  push;
    logic                  pop;

    assign empty = (count == 2'd0);
    // Store the incoming word unless it flows straight through this cycle.
    assign push  = in_valid && !(empty && out_ready);
    assign pop   = out_ready && !empty;

    assign out_valid = !empty || in_valid;
    assign out_data  = !empty  ? mem[rd_ptr] :
                       in_valid ? in_data    : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // NOTE: storage entries carry no reset; count gates their visibility, so
    // stale contents can never reach out_data.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/ext_msg_seq.sv
// ext_msg_seq -- extrinsic message sequencer for one check-node row pass.
// On start it reads row_deg old messages from the extrinsic RAM (base+k),
// streams them to the check-node unit, then writes the row_deg updated
// messages coming back to the same addresses and pulses done.
// Optional feature macro: EXT_FIRST_ITER_ZERO_EN -- when defined and
// first_iter is latched high, the read phase streams zeros without touching
// the RAM. Default build: first_iter is ignored.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   start, row_base, row_deg, first_iter  row request (sampled in IDLE)
//   busy, done                         status
//   ram_addr, ram_din, ram_cs, ram_we  single-port RAM controls
//   ram_dout                           RAM read data (one cycle latency)
//   msg_data, msg_valid, msg_ready     old-message stream out
//   wb_data, wb_valid, wb_ready        updated-message stream in
module ext_msg_seq
    import ldpc_pkg::*;
#(
    parameter int DATA_WIDTH = LDPC_DATA_WIDTH,
    parameter int ADDR_WIDTH = LDPC_ADDR_WIDTH,
    parameter int DEG_WIDTH  = LDPC_DEG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] row_base,
    input  logic [DEG_WIDTH-1:0]  row_deg,
    input  logic                  first_iter,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_cs,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] msg_data,
    output logic                  msg_valid,
    input  logic                  msg_ready,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  wb_valid,
    output logic                  wb_ready
);

    localparam logic [DEG_WIDTH-1:0] DEG_ONE = 1;

    seq_state_e            state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [DEG_WIDTH-1:0]  deg_q;
    logic [DEG_WIDTH-1:0]  deg_last;
    logic [DEG_WIDTH-1:0]  rd_cnt;
    logic [DEG_WIDTH-1:0]  msg_cnt;
    logic [DEG_WIDTH-1:0]  wr_cnt;
    logic                  rd_pend;     // a read issued last cycle lands this cycle
    logic                  issue;
    logic                  pop;
    logic                  wr_fire;
    logic                  zero_mode;
    logic [1:0]            buf_count;
    logic [2:0]            occ;
    logic [DATA_WIDTH-1:0] buf_in_data;

`ifdef EXT_FIRST_ITER_ZERO_EN
    logic zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        zero_q <= 1'b0;
        else if (state == ST_IDLE && start) zero_q <= first_iter;
    end

    assign zero_mode = zero_q;
`else
    logic unused_first_iter;

    assign unused_first_iter = first_iter;
    assign zero_mode         = 1'b0;
`endif

    assign deg_last    = deg_q - DEG_ONE;
    assign pop         = msg_valid && msg_ready;
    assign buf_in_data = zero_mode ? '0 : ram_dout;
    // Words held after this edge (stored plus landing, minus the one leaving);
    // one more read may launch only if its word will still find a slot.
    assign occ = {1'b0, buf_count} + {2'b00, rd_pend} - {2'b00, pop};

    ext_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rd_pend),
        .in_data  (buf_in_data),
        .out_valid(msg_valid),
        .out_data (msg_data),
        .out_ready(msg_ready),
        .count    (buf_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            base_q  <= '0;
            deg_q   <= '0;
            rd_cnt  <= '0;
            msg_cnt <= '0;
            wr_cnt  <= '0;
            rd_pend <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_pend <= issue;
            if (state == ST_IDLE && start) begin
                base_q  <= row_base;
                deg_q   <= row_deg;
                rd_cnt  <= '0;
                msg_cnt <= '0;
                wr_cnt  <= '0;
            end else begin
                if (issue)   rd_cnt  <= rd_cnt + DEG_ONE;
                if (pop)     msg_cnt <= msg_cnt + DEG_ONE;
                if (wr_fire) wr_cnt  <= wr_cnt + DEG_ONE;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would infer a latch.
        state_nxt = state;
        issue     = 1'b0;
        wr_fire   = 1'b0;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        wb_ready  = 1'b0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);

        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = (row_deg == '0) ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                if (rd_cnt < deg_q && occ <= 3'd1) begin
                    issue = 1'b1;
                    if (!zero_mode) begin
                        ram_cs   = 1'b1;
                        ram_addr = base_q + ADDR_WIDTH'(rd_cnt);
                    end
                end
                if (pop && msg_cnt == deg_last) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                wb_ready = 1'b1;
                if (wb_valid) begin
                    wr_fire  = 1'b1;
                    ram_cs   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = base_q + ADDR_WIDTH'(wr_cnt);
                    ram_din  = wb_data;
                    if (wr_cnt == deg_last) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ext_msg_seq.sv
// tb_ext_msg_seq -- directed bench for ext_msg_seq with a behavioural
// single-port RAM and a scoreboard of expected old messages.
module tb_ext_msg_seq;
    import ldpc_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int GW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] row_base = '0;
    logic [GW-1:0] row_deg = '0;
    logic          first_iter = 1'b0;
    logic          busy, done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_cs, ram_we;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] msg_data;
    logic          msg_valid;
    logic          msg_ready = 1'b1;
    logic [DW-1:0] wb_data = '0;
    logic          wb_valid = 1'b0;
    logic          wb_ready;

    always #5 clk = ~clk;

    ext_msg_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEG_WIDTH(GW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .row_base(row_base),
        .row_deg(row_deg), .first_iter(first_iter), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_cs(ram_cs), .ram_we(ram_we),
        .ram_dout(ram_dout), .msg_data(msg_data), .msg_valid(msg_valid),
        .msg_ready(msg_ready), .wb_data(wb_data), .wb_valid(wb_valid),
        .wb_ready(wb_ready)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- RAM model and monitors ----------------
    logic [DW-1:0] ram [256];
    logic [DW-1:0] exp_ram [256];
    logic          preloaded = 1'b0;
    int            rd_strobes = 0;
    int            wr_strobes = 0;
    logic [AW-1:0] rd_log [256];
    logic [AW-1:0] wr_log [256];
    int            done_cnt = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] obs_q [$];

    function automatic logic [DW-1:0] init_val(input int a);
        if (a >= 32 && a <= 36) return DW'(a - 32 + 10);
        return DW'(a * 7 + 3);
    endfunction

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            preloaded <= 1'b1;
        end else begin
            if (ram_cs && !ram_we) begin
                ram_dout           <= ram[ram_addr];
                rd_log[rd_strobes] <= ram_addr;
                rd_strobes         <= rd_strobes + 1;
            end
            if (ram_cs && ram_we) begin
                ram[ram_addr]      <= ram_din;
                wr_log[wr_strobes] <= ram_addr;
                wr_strobes         <= wr_strobes + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (msg_valid && msg_ready) obs_q.push_back(msg_data);
        if (done) done_cnt <= done_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {2'b00, busy, done, msg_valid, wb_ready, ram_cs, ram_we, ram_addr, ram_din, msg_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] base, input int deg, input logic fi);
        start = 1'b1; row_base = base; row_deg = GW'(deg); first_iter = fi;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_row(input logic [AW-1:0] base, input int deg, input bit zero);
        for (int k = 0; k < deg; k++)
            exp_q.push_back(zero ? '0 : exp_ram[AW'(base + k)]);
    endtask

    task automatic wait_stream(input int limit, input bit rnd);
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < limit) begin
            if (rnd) msg_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        msg_ready = 1'b1;
        check("stream_in_time", (n < limit) ? 1 : 0, 1);
    endtask

    task automatic drain_compare(input string tag);
        check({tag, "_msg_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_msg"}, obs_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic send_writes(input logic [AW-1:0] base, input int cnt, input int first_val);
        int n;
        int tmo;
        tmo = 0;
        for (int j = 0; j < cnt; j++) begin
            wb_valid = 1'b1;
            wb_data  = DW'(first_val + j);
            n = 0;
            @(negedge clk);
            while (!wb_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) tmo++;
            exp_ram[AW'(base + j)] = DW'(first_val + j);
            tick();
        end
        wb_valid = 1'b0;
        check("wb_ready_in_time", tmo, 0);
    endtask

    task automatic do_row(input logic [AW-1:0] base, input int deg, input logic fi,
                          input bit rnd, input int wbv, input string tag);
        int r0, w0, d0;
        bit zero;
        zero = 1'b0;
`ifdef EXT_FIRST_ITER_ZERO_EN
        zero = fi;
`endif
        r0 = rd_strobes; w0 = wr_strobes; d0 = done_cnt;
        expect_row(base, deg, zero);
        pulse_start(base, deg, fi);
        wait_stream(400, rnd);
        drain_compare(tag);
        check({tag, "_read_strobes"}, rd_strobes - r0, zero ? 0 : deg);
        if (!zero)
            for (int k = 0; k < deg; k++)
                check({tag, "_read_addr"}, rd_log[r0 + k], AW'(base + k));
        send_writes(base, deg, wbv);
        check({tag, "_done_high"}, done, 1);
        tick();
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_idle"}, {busy, done}, 0);
        check({tag, "_write_strobes"}, wr_strobes - w0, deg);
        for (int k = 0; k < deg; k++) begin
            check({tag, "_write_addr"}, wr_log[w0 + k], AW'(base + k));
            check({tag, "_ram_word"}, ram[AW'(base + k)], exp_ram[AW'(base + k)]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int r0, w0, d0, c0, n;
        for (int i = 0; i < 256; i++) exp_ram[i] = init_val(i);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 0);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", outs(), 0);

        // Row 0x20, deg 5: latency and back-to-back streaming
        d0 = done_cnt;
        expect_row(8'h20, 5, 1'b0);
        pulse_start(8'h20, 5, 1'b0);
        @(negedge clk);
        check("cycle1_busy", busy, 1);
        check("cycle1_no_msg", msg_valid, 0);
        check("cycle1_read_addr", {ram_cs, ram_we, ram_addr}, {2'b10, 8'h20});
        @(negedge clk);
        check("cycle2_msg_valid", msg_valid, 1);
        check("cycle2_msg_data", msg_data, 10);
        repeat (4) @(negedge clk);
        #1;
        check("stream_consecutive", obs_q.size(), 5);
        tick();
        check("write_phase_ready", wb_ready, 1);
        drain_compare("row20");
        send_writes(8'h20, 5, 50);
        check("row20_done_high", done, 1);
        tick();
        check("row20_done_pulses", done_cnt - d0, 1);
        for (int k = 0; k < 5; k++) check("row20_ram_word", ram[8'h20 + k], 50 + k);

        // Degree zero: done without any RAM access
        d0 = done_cnt; c0 = rd_strobes + wr_strobes;
        pulse_start(8'h30, 0, 1'b0);
        n = 0;
        while (done_cnt == d0 && n < 4) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("deg0_done_within_2", (n <= 2) ? 1 : 0, 1);
        tick();
        tick();
        check("deg0_done_pulses", done_cnt - d0, 1);
        check("deg0_no_ram_cs", rd_strobes + wr_strobes - c0, 0);
        check("deg0_idle", busy, 0);

        // Address wrap past the top of the RAM
        do_row(8'hFE, 4, 1'b0, 1'b0, 20, "wrap");

        // Random consumer back-pressure
        do_row(8'h60, 12, 1'b0, 1'b1, 100, "rand_ready");

        // Reset in the middle of the write phase
        w0 = wr_strobes;
        expect_row(8'h40, 5, 1'b0);
        pulse_start(8'h40, 5, 1'b0);
        wait_stream(100, 1'b0);
        drain_compare("rst_row");
        send_writes(8'h40, 2, 70);
        wb_valid = 1'b1;
        wb_data  = 8'd72;
        rst_n    = 1'b0;
        #1;
        check("midrow_reset_outputs", outs(), 0);
        tick();
        wb_valid = 1'b0;
        rst_n    = 1'b1;
        check("midrow_reset_writes", wr_strobes - w0, 2);
        for (int k = 2; k < 5; k++) check("midrow_untouched", ram[8'h40 + k], exp_ram[8'h40 + k]);
        tick();

        // first_iter row (zeros when the feature is built in, RAM otherwise)
        r0 = rd_strobes;
        do_row(8'h50, 3, 1'b1, 1'b0, 90, "first_iter");
        check("first_iter_total_reads", rd_strobes - r0,
`ifdef EXT_FIRST_ITER_ZERO_EN
              0
`else
              3
`endif
        );

        // Row after reset and rewrite: reads back the updated words
        do_row(8'h20, 5, 1'b0, 1'b1, 150, "reread");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
